// File: rtl/sel_pkg.sv
// Shared constants for the front-panel mode/value selector: value limits and debouncer state encoding.
package sel_pkg;

  localparam logic [2:0] FREQ_MAX  = 3'd7;
  localparam logic [3:0] CORR_MIN  = 4'd1;
  localparam logic [3:0] CORR_MAX  = 4'd10;
  localparam logic       MODO_FREQ = 1'b1;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE       = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT_PRESS = 2'd1;
  localparam logic [ST_W-1:0] ST_PRESSED    = 2'd2;
  localparam logic [ST_W-1:0] ST_WAIT_REL   = 2'd3;

endpackage

// File: rtl/antirrebote.sv
// One pushbutton front end: 2-flop synchronizer followed by a press/release debouncer FSM.
module antirrebote
  import sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic clk_i,
  input  logic reset,
  input  logic raw_i,
  output logic press_o,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic [ST_W-1:0]  state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             cnt_done;

  assign sync     = sync_q[1];
  assign cnt_done = (cnt_q == CNT_END);

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Counter only runs while waiting for the synchronized level to stay stable; any other path clears it.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = '0;
    press_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) state_nx = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (!sync) begin
          state_nx = ST_IDLE;
        end else if (cnt_done) begin
          state_nx = ST_PRESSED;
          press_o  = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync) state_nx = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (sync) begin
          state_nx = ST_PRESSED;
        end else if (cnt_done) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign level_o = (state_q == ST_PRESSED) || (state_q == ST_WAIT_REL);

endmodule

// File: rtl/selector_modo_valor.sv
// Front-panel selector: three debounced buttons drive mode, frequency index and current step.
// Optional auto-repeat on held up/down buttons when SEL_AUTOREPEAT_EN is defined.
module selector_modo_valor
  import sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_CYC   = 25000000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       btn_modo_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic       modo_o,
  output logic [2:0] valorf_o,
  output logic [3:0] valorC_o,
  output logic       cambio_o
);

  logic [2:0] press;
  logic [2:0] lvl;
  logic       unused_lvl;
  logic       step_up, step_dn;
  logic       modo_q, modo_nx;
  logic [2:0] valf_q, valf_nx;
  logic [3:0] valc_q, valc_nx;
  logic       cambio_q, cambio_nx;

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_ar_modo (
    .clk_i(clk_i), .reset(reset), .raw_i(btn_modo_i), .press_o(press[0]), .level_o(lvl[0]));
  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_ar_up (
    .clk_i(clk_i), .reset(reset), .raw_i(btn_up_i), .press_o(press[1]), .level_o(lvl[1]));
  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_ar_down (
    .clk_i(clk_i), .reset(reset), .raw_i(btn_down_i), .press_o(press[2]), .level_o(lvl[2]));

  assign unused_lvl = ^lvl;

`ifdef SEL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_END = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] rep_q;
  logic             held;
  logic             rep_fire;

  assign held     = lvl[1] | lvl[2];
  assign rep_fire = held && (rep_q == REP_END);

  // Repeat period is re-anchored on every press pulse and on every generated repeat step.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else if (!held || (|press) || rep_fire) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + CNT_W'(1);
    end
  end

  assign step_up = press[1] | (rep_fire & lvl[1]);
  assign step_dn = press[2] | (rep_fire & lvl[2]);
`else
  logic unused_cfg;

  assign unused_cfg = ^CNT_W'(REPEAT_CYC);
  assign step_up    = press[1];
  assign step_dn    = press[2];
`endif

  // Mode wins over steps; simultaneous up+down cancel; values saturate at their limits.
  always_comb begin
    modo_nx = modo_q;
    valf_nx = valf_q;
    valc_nx = valc_q;
    if (press[0]) begin
      modo_nx = ~modo_q;
    end else if (step_up ^ step_dn) begin
      if (modo_q == MODO_FREQ) begin
        if (step_up && (valf_q != FREQ_MAX)) valf_nx = valf_q + 3'd1;
        if (step_dn && (valf_q != 3'd0))     valf_nx = valf_q - 3'd1;
      end else begin
        if (step_up && (valc_q != CORR_MAX)) valc_nx = valc_q + 4'd1;
        if (step_dn && (valc_q != CORR_MIN)) valc_nx = valc_q - 4'd1;
      end
    end
    cambio_nx = (modo_nx != modo_q) || (valf_nx != valf_q) || (valc_nx != valc_q);
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      modo_q   <= MODO_FREQ;
      valf_q   <= 3'd0;
      valc_q   <= CORR_MIN;
      cambio_q <= 1'b0;
    end else begin
      modo_q   <= modo_nx;
      valf_q   <= valf_nx;
      valc_q   <= valc_nx;
      cambio_q <= cambio_nx;
    end
  end

  assign modo_o   = modo_q;
  assign valorf_o = valf_q;
  assign valorC_o = valc_q;
  assign cambio_o = cambio_q;

endmodule
